// File: rtl/rf_replay_writer.sv
// Replay-side register-file restorer: snoops committed core writes into a shadow
// copy and, while the core is halted, replays shadow values back into the core RF.
module rf_replay_writer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  input  logic                  halt_i,
  input  logic [ADDR_WIDTH-1:0] replay_addr_i,
  input  logic                  shift_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  restore_busy_o,
  output logic                  restore_done_o,
  output logic                  restore_err_o,
  output logic [ADDR_WIDTH:0]   covered_cnt_o
);

  localparam int NUM_REG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH + 1)'(NUM_REG);

  typedef enum logic [1:0] {S_IDLE, S_RESTORE, S_WAIT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shadow [NUM_REG];
  logic [NUM_REG-1:0]    r_mask;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic w_new_bit;
  logic w_drop_r0;
  logic w_mask_full;

  assign w_new_bit   = ~r_mask[replay_addr_i];
  assign w_drop_r0   = R0_HARDWIRED && (core_waddr_i == '0);
  assign w_mask_full = &r_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < NUM_REG; i++) r_shadow[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
          if (halt_i) begin
            // Halt wins over a same-cycle core write: that data is suspect.
            r_state <= S_RESTORE;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_mask  <= {{(NUM_REG-1){1'b0}}, R0_HARDWIRED};
            r_cnt   <= {{ADDR_WIDTH{1'b0}}, R0_HARDWIRED};
          end else if (core_we_i && !w_drop_r0) begin
            r_shadow[core_waddr_i] <= core_wdata_i;
          end
        end
        S_RESTORE: begin
          r_done <= 1'b0;
          if (!halt_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
          end else if (shift_i) begin
            r_state <= S_WAIT;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= ~w_mask_full;
          end else begin
            r_we    <= 1'b1;
            r_waddr <= replay_addr_i;
            r_wdata <= r_shadow[replay_addr_i];
            r_mask[replay_addr_i] <= 1'b1;
            if (w_new_bit && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
          if (!halt_i) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rf_we_o        = r_we;
  assign rf_waddr_o     = r_waddr;
  assign rf_wdata_o     = r_wdata;
  assign restore_busy_o = r_busy;
  assign restore_done_o = r_done;
  assign restore_err_o  = r_err;
  assign covered_cnt_o  = r_cnt;

endmodule

// File: tb/tb_rf_replay_writer.sv
// Bench for rf_replay_writer: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_rf_replay_writer;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_we;
  logic [AW-1:0] core_waddr;
  logic [DW-1:0] core_wdata;
  logic          halt;
  logic [AW-1:0] raddr;
  logic          shift;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   cnt;

  int checks = 0;
  int errors = 0;

  rf_replay_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .R0_HARDWIRED(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .halt_i(halt), .replay_addr_i(raddr), .shift_i(shift),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .restore_busy_o(busy), .restore_done_o(done), .restore_err_o(err),
    .covered_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = normal snooping, 1 = restoring, 2 = waiting for halt release.
  int            m_mode;
  logic [DW-1:0] m_shadow [NR];
  bit            m_cov [NR];
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic          m_done;
  logic          m_err;

  function automatic int cov_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_cov[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_we    <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
      m_done  <= 1'b0;
      m_err   <= 1'b0;
      for (int i = 0; i < NR; i++) begin
        m_shadow[i] <= '0;
        m_cov[i]    <= 1'b0;
      end
    end else begin
      m_we   <= 1'b0;
      m_done <= 1'b0;
      if (m_mode == 0) begin
        if (halt) begin
          m_mode <= 1;
          m_err  <= 1'b0;
          for (int i = 0; i < NR; i++) m_cov[i] <= (i == 0);
        end else if (core_we && core_waddr != 0) begin
          m_shadow[core_waddr] <= core_wdata;
        end
      end else if (m_mode == 1) begin
        if (!halt) begin
          m_mode <= 0;
          m_err  <= 1'b1;
        end else if (shift) begin
          m_mode <= 2;
          m_done <= 1'b1;
          m_err  <= (cov_count() != NR);
        end else begin
          m_we         <= 1'b1;
          m_waddr      <= raddr;
          m_wdata      <= m_shadow[raddr];
          m_cov[raddr] <= 1'b1;
        end
      end else begin
        if (!halt) m_mode <= 0;
      end
    end
  end

  task automatic compare_all();
    int exp_cnt;
    logic exp_busy;
    exp_cnt  = cov_count();
    exp_busy = (m_mode == 1);
    checks++;
    if (rf_we !== m_we || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata)) ||
        busy !== exp_busy || done !== m_done || err !== m_err || int'(cnt) != exp_cnt) begin
      errors++;
      $display("FAIL outputs t=%0t actual/required: we %0b/%0b waddr %0h/%0h wdata %h/%h busy %0b/%0b done %0b/%0b err %0b/%0b cnt %0d/%0d",
               $time, rf_we, m_we, rf_waddr, m_waddr, rf_wdata, m_wdata, busy, exp_busy,
               done, m_done, err, m_err, cnt, exp_cnt);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic h, input logic [AW-1:0] ra, input logic sh);
    core_we = we; core_waddr = wa; core_wdata = wd;
    halt = h; raddr = ra; shift = sh;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic sweep(input int n);
    for (int a = 0; a < n; a++) step(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
  endtask

  task automatic finish_sweep();
    step(1'b0, '0, '0, 1'b1, '0, 1'b1);
  endtask

  initial begin
    bit h;
    int seq;
    core_we = 0; core_waddr = '0; core_wdata = '0; halt = 0; raddr = '0; shift = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_we", 64'(rf_we), 0);
    chk("reset_cnt", 64'(cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: snoop two writes, full sweep
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    step(1'b1, 5'd31, 32'h1234, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_cnt_entry", 64'(cnt), 1);
    for (int a = 0; a < NR; a++) begin
      step(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
      if (a == 5)  chk("t1_w5", 64'(rf_wdata), 64'hDEADBEEF);
      if (a == 31) chk("t1_w31", 64'(rf_wdata), 64'h1234);
      if (a == 12) chk("t1_w12", 64'(rf_wdata), 0);
    end
    finish_sweep();
    chk("t1_done", 64'(done), 1);
    chk("t1_err", 64'(err), 0);
    chk("t1_cnt", 64'(cnt), 32);
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    chk("t1_done_once", 64'(done), 0);
    idle(2);

    // 2: short sweep
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    sweep(16);
    finish_sweep();
    chk("t2_cnt", 64'(cnt), 16);
    chk("t2_err", 64'(err), 1);
    idle(2);

    // 3: core write collides with halt rising
    step(1'b1, 5'd7, 32'hAA, 1'b1, '0, 1'b0);
    for (int a = 0; a < NR; a++) begin
      step(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
      if (a == 7) chk("t3_w7", 64'(rf_wdata), 0);
    end
    finish_sweep();
    idle(2);

    // 4: write to hardwired r0 is dropped
    step(1'b1, 5'd0, 32'h55, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 5'd0, 1'b0);
    chk("t4_w0_addr", 64'(rf_waddr), 0);
    chk("t4_w0_data", 64'(rf_wdata), 0);
    sweep(NR);
    finish_sweep();
    chk("t4_cnt", 64'(cnt), 32);
    chk("t4_err", 64'(err), 0);
    idle(2);

    // 5: abort by halt drop, then a clean sweep
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    sweep(10);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("t5_done", 64'(done), 0);
    chk("t5_err", 64'(err), 1);
    chk("t5_busy", 64'(busy), 0);
    idle(1);
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    sweep(NR);
    finish_sweep();
    chk("t5_err_clear", 64'(err), 0);
    idle(2);

    // 6: async reset in the middle of a restore
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    sweep(4);
    rst_n = 1'b0;
    #1;
    chk("t6_we", 64'(rf_we), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_cnt", 64'(cnt), 0);
    chk("t6_wdata", 64'(rf_wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
    for (int a = 0; a < NR; a++) begin
      step(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
      if (a == 5 || a == 31) chk("t6_zero", 64'(rf_wdata), 0);
    end
    finish_sweep();
    idle(2);

    // Random traffic against the model
    h = 1'b0;
    seq = 0;
    for (int c = 0; c < 3000; c++) begin
      logic sh;
      logic [AW-1:0] ra;
      sh = 1'b0;
      if (!h) begin
        if ($urandom_range(14) == 0) begin h = 1'b1; seq = 0; end
      end else begin
        if ($urandom_range(59) == 0) h = 1'b0;
        else if ($urandom_range(39) == 0) sh = 1'b1;
      end
      ra = ($urandom_range(4) == 0) ? AW'($urandom) : AW'(seq);
      seq++;
      step(1'($urandom), AW'($urandom), $urandom, h, ra, sh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
